// File: rtl/udp_checksum_gen.sv
// udp_checksum_gen
// Transmit-side UDP checksum generator. Accumulates a packet of 16-bit
// big-endian words into a 32-bit sum. It then folds the carries back in
// twice and presents the ones'-complement result with a valid/ready handshake.
// INIT_SUM lets a precomputed pseudo-header partial sum be folded into the
// first word of every packet.

module udp_checksum_gen #(
    parameter logic [15:0] INIT_SUM = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_word,
    input  logic        i_valid,
    input  logic        i_last,
    input  logic        i_odd,
    output logic        o_ready,
    output logic [15:0] o_checksum,
    output logic        o_checksum_valid,
    input  logic        i_checksum_ready,
    output logic [15:0] o_word_count
);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        FOLD1,
        FOLD2,
        OUT
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] sum;
    logic        word_xfer;
    logic        csum_xfer;
    logic [15:0] word_eff;
    logic [16:0] fold1_sum;
    logic [15:0] fold2_f;
    logic [15:0] fold2_c;

    // The word-side handshake depends only on state, so o_ready never
    // combinationally follows i_valid.
    assign o_ready   = (state == IDLE) || (state == ACCUM);
    assign word_xfer = i_valid && o_ready;
    assign csum_xfer = o_checksum_valid && i_checksum_ready;

    // On an odd-length final word, only the high byte is payload.
    // The low byte is zero padding.
    assign word_eff  = (i_odd && i_last) ? {i_word[15:8], 8'h00} : i_word;

    // First fold: the 32-bit sum becomes at most 17 bits. Second fold: the
    // remaining carry goes back in. After the first fold, sum[15:0] is at most
    // 16'hFFFE whenever sum[16] is set, so the second fold cannot carry out.
    assign fold1_sum = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
    assign fold2_f   = sum[15:0] + {15'h0000, sum[16]};
    assign fold2_c   = ~fold2_f;

    // State register; reset drops any packet in progress back to IDLE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept words until the last one, run two fold cycles,
    // then wait for the downstream to take the checksum.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (word_xfer) begin
                    state_next = i_last ? FOLD1 : ACCUM;
                end
            end
            ACCUM: begin
                if (word_xfer && i_last) begin
                    state_next = FOLD1;
                end
            end
            FOLD1: begin
                state_next = FOLD2;
            end
            FOLD2: begin
                state_next = OUT;
            end
            OUT: begin
                if (csum_xfer) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The accumulator loads the seed with the first word, adds later words,
    // is folded down in FOLD1 and is cleared once the checksum has been taken.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sum <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (word_xfer) begin
                        sum <= {16'h0000, INIT_SUM} + {16'h0000, word_eff};
                    end
                end
                ACCUM: begin
                    if (word_xfer) begin
                        sum <= sum + {16'h0000, word_eff};
                    end
                end
                FOLD1: begin
                    sum <= {15'h0000, fold1_sum};
                end
                OUT: begin
                    if (csum_xfer) begin
                        sum <= 32'h0000_0000;
                    end
                end
                default: begin
                    sum <= sum;
                end
            endcase
        end
    end

    // The word counter restarts at 1 on a packet's first word and saturates.
    // It keeps the last packet's count until the next packet begins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_word_count <= 16'h0000;
        end else if (word_xfer) begin
            if (state == IDLE) begin
                o_word_count <= 16'h0001;
            end else if (o_word_count != 16'hFFFF) begin
                o_word_count <= o_word_count + 16'h0001;
            end
        end
    end

    // A zero complement is sent as 16'hFFFF, because zero on the wire means
    // "no checksum". The value stays on o_checksum after the handshake.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_checksum       <= 16'h0000;
            o_checksum_valid <= 1'b0;
        end else if (state == FOLD2) begin
            o_checksum       <= (fold2_c == 16'h0000) ? 16'hFFFF : fold2_c;
            o_checksum_valid <= 1'b1;
        end else if ((state == OUT) && csum_xfer) begin
            o_checksum_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_udp_checksum_gen.sv
// tb_udp_checksum_gen
// Directed bench for udp_checksum_gen. It uses hand-computed checksum vectors,
// fold latency, back-pressure and mid-packet reset. A second instance seeded
// with 16'h1234 shares the same stimulus for the pseudo-header seed case.

module tb_udp_checksum_gen;

    logic        i_clk;
    logic        i_rst;
    logic [15:0] i_word;
    logic        i_valid;
    logic        i_last;
    logic        i_odd;
    logic        i_checksum_ready;

    logic        o_ready;
    logic [15:0] o_checksum;
    logic        o_checksum_valid;
    logic [15:0] o_word_count;

    logic        seed_ready;
    logic [15:0] seed_checksum;
    logic        seed_checksum_valid;
    logic [15:0] seed_word_count;

    int tests_run;
    int tests_failed;

    udp_checksum_gen #(.INIT_SUM(16'h0000)) u_dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_word           (i_word),
        .i_valid          (i_valid),
        .i_last           (i_last),
        .i_odd            (i_odd),
        .o_ready          (o_ready),
        .o_checksum       (o_checksum),
        .o_checksum_valid (o_checksum_valid),
        .i_checksum_ready (i_checksum_ready),
        .o_word_count     (o_word_count)
    );

    udp_checksum_gen #(.INIT_SUM(16'h1234)) u_dut_seed (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_word           (i_word),
        .i_valid          (i_valid),
        .i_last           (i_last),
        .i_odd            (i_odd),
        .o_ready          (seed_ready),
        .o_checksum       (seed_checksum),
        .o_checksum_valid (seed_checksum_valid),
        .i_checksum_ready (i_checksum_ready),
        .o_word_count     (seed_word_count)
    );

    // 10 ns clock; rising edges at 5, 15, 25, ...
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Compares one observed value against its expectation and tallies the result.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Presents one word and holds it until accepted, giving up after a bounded
    // number of cycles. Returns 1 ns after the accepting edge.
    task automatic applyStimulus(input logic [15:0] word, input logic last,
                                 input logic odd);
        int waited;
        waited  = 0;
        i_word  = word;
        i_valid = 1'b1;
        i_last  = last;
        i_odd   = odd;
        while (!o_ready && waited < 20) begin
            @(posedge i_clk);
            #1;
            waited++;
        end
        checkOutput("word_ready", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_odd   = 1'b0;
        i_word  = 16'h0000;
    endtask

    // Called 1 ns after the last-word edge k. Checks that valid rises exactly
    // after edge k+2 with the right checksum and count. Then it optionally holds
    // back-pressure with a stray word on i_valid and completes the handshake.
    task automatic collectChecksum(input string tag, input logic [15:0] exp_csum,
                                   input logic [15:0] exp_count, input int hold);
        // With no back-pressure, ready is raised early to show it has no effect
        // while valid is low.
        i_checksum_ready = (hold == 0);
        checkOutput({tag, "_fold1_valid"}, {31'd0, o_checksum_valid}, 32'd0);
        @(posedge i_clk);
        #1;
        checkOutput({tag, "_fold2_valid"}, {31'd0, o_checksum_valid}, 32'd0);
        @(posedge i_clk);
        #1;
        checkOutput({tag, "_valid"}, {31'd0, o_checksum_valid}, 32'd1);
        checkOutput({tag, "_csum"}, {16'd0, o_checksum}, {16'd0, exp_csum});
        checkOutput({tag, "_count"}, {16'd0, o_word_count}, {16'd0, exp_count});
        if (hold > 0) begin
            i_word  = 16'hBEEF;
            i_valid = 1'b1;
            i_last  = 1'b1;
            for (int c = 0; c < hold; c++) begin
                @(posedge i_clk);
                #1;
                checkOutput({tag, "_bp_valid"}, {31'd0, o_checksum_valid}, 32'd1);
                checkOutput({tag, "_bp_csum"}, {16'd0, o_checksum}, {16'd0, exp_csum});
                checkOutput({tag, "_bp_ready"}, {31'd0, o_ready}, 32'd0);
                checkOutput({tag, "_bp_count"}, {16'd0, o_word_count}, {16'd0, exp_count});
            end
            i_valid = 1'b0;
            i_last  = 1'b0;
            i_word  = 16'h0000;
            i_checksum_ready = 1'b1;
        end
        @(posedge i_clk);
        #1;
        i_checksum_ready = 1'b0;
        checkOutput({tag, "_done_valid"}, {31'd0, o_checksum_valid}, 32'd0);
        checkOutput({tag, "_done_ready"}, {31'd0, o_ready}, 32'd1);
        checkOutput({tag, "_retained"}, {16'd0, o_checksum}, {16'd0, exp_csum});
    endtask

    // Sends the RFC 1071 example packet.
    task automatic sendRfcPacket();
        applyStimulus(16'h0001, 1'b0, 1'b0);
        applyStimulus(16'hF203, 1'b0, 1'b0);
        applyStimulus(16'hF4F5, 1'b0, 1'b0);
        applyStimulus(16'hF6F7, 1'b1, 1'b0);
    endtask

    // Main directed sequence.
    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        i_rst            = 1'b1;
        i_word           = 16'h0000;
        i_valid          = 1'b0;
        i_last           = 1'b0;
        i_odd            = 1'b0;
        i_checksum_ready = 1'b0;

        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("rst_csum", {16'd0, o_checksum}, 32'd0);
        checkOutput("rst_valid", {31'd0, o_checksum_valid}, 32'd0);
        checkOutput("rst_count", {16'd0, o_word_count}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput("rst_ready", {31'd0, o_ready}, 32'd1);

        // 0x2DDF0 folds to 0xDDF2, and its complement is 0x220D.
        sendRfcPacket();
        collectChecksum("rfc", 16'h220D, 16'd4, 0);

        // 0x1FFFF folds to 0x10000 and then to 0x0001, giving 0xFFFE.
        applyStimulus(16'hFFFF, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 1'b0, 1'b0);
        applyStimulus(16'h0001, 1'b1, 1'b0);
        collectChecksum("dfold", 16'hFFFE, 16'd3, 0);

        // The complement of 0xFFFF is zero, which is sent as 0xFFFF.
        applyStimulus(16'hFFFF, 1'b1, 1'b0);
        collectChecksum("zero1", 16'hFFFF, 16'd1, 0);

        // Unseeded sum 0xEDCB gives 0x1234. The seeded copy sums to 0xFFFF,
        // which also maps to 0xFFFF.
        applyStimulus(16'h0000, 1'b0, 1'b0);
        applyStimulus(16'hEDCB, 1'b1, 1'b0);
        collectChecksum("zero2", 16'h1234, 16'd2, 0);
        checkOutput("seed_zero_map", {16'd0, seed_checksum}, 32'h0000_FFFF);
        checkOutput("seed_count", {16'd0, seed_word_count}, 32'd2);

        // The odd final word keeps only its high byte: 0x1234 + 0x5600 = 0x6834.
        applyStimulus(16'h1234, 1'b0, 1'b0);
        applyStimulus(16'h56AB, 1'b1, 1'b1);
        collectChecksum("odd", 16'h97CB, 16'd2, 0);

        // 0x1111 + 0x2222 = 0x3333 gives 0xCCCC. The stray word during
        // back-pressure must not be consumed.
        applyStimulus(16'h1111, 1'b0, 1'b0);
        applyStimulus(16'h2222, 1'b1, 1'b0);
        collectChecksum("bp", 16'hCCCC, 16'd2, 5);
        // A fresh single-word packet must not inherit the previous sum.
        applyStimulus(16'h0F0F, 1'b1, 1'b0);
        collectChecksum("after_bp", 16'hF0F0, 16'd1, 0);

        // Asynchronous reset partway through a packet.
        applyStimulus(16'h0001, 1'b0, 1'b0);
        applyStimulus(16'hF203, 1'b0, 1'b0);
        #3;
        i_rst = 1'b1;
        #1;
        checkOutput("mid_rst_csum", {16'd0, o_checksum}, 32'd0);
        checkOutput("mid_rst_valid", {31'd0, o_checksum_valid}, 32'd0);
        checkOutput("mid_rst_count", {16'd0, o_word_count}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        sendRfcPacket();
        collectChecksum("rfc_again", 16'h220D, 16'd4, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/udp_checksum_gen.md
# udp_checksum_gen

Transmit-side UDP checksum generator: accumulates a packet presented as a stream of 16-bit big-endian words and produces the 16-bit ones'-complement checksum to insert into the UDP header. It sits in the TX path ahead of the header inserter and is the generating counterpart of the RX checksum verifier. A parameterised seed allows a precomputed pseudo-header sum to be folded in.

## Interface
- INIT_SUM, 16'h0000, seed added to the accumulator on the first word of every packet (pseudo-header partial sum)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_word  in  16  packet word, first byte in [15:8]
- i_valid  in  1  i_word valid
- i_last  in  1  i_word is the final word of the packet
- i_odd  in  1  with i_last: only [15:8] is payload; [7:0] is treated as 8'h00; ignored when i_last=0
- o_ready  out  1  block accepts a word this cycle
- o_checksum  out  16  final checksum
- o_checksum_valid  out  1  o_checksum is valid; held until accepted
- i_checksum_ready  in  1  downstream accepts o_checksum
- o_word_count  out  16  words accepted in current/last packet, saturating at 16'hFFFF

## Operation
- Word transfer = i_valid & o_ready at a rising edge. Checksum transfer = o_checksum_valid & i_checksum_ready.
- States: IDLE, ACCUM, FOLD1, FOLD2, OUT.
- IDLE: o_ready=1. On transfer: sum <= INIT_SUM + w, o_word_count <= 1; next ACCUM, or FOLD1 if i_last.
- ACCUM: o_ready=1. On transfer: sum <= sum + w, count increments (saturating); to FOLD1 if i_last. No transfer: hold.
- w = i_odd&i_last ? {i_word[15:8],8'h00} : i_word.
- sum is a 32-bit unsigned accumulator; no overflow possible for packets up to 65535 words.
- FOLD1: sum <= sum[15:0] + sum[31:16] (result ≤ 17 bits); next FOLD2. o_ready=0.
- FOLD2: f = sum[15:0] + sum[16]; c = ~f[15:0]; o_checksum <= (c==16'h0000) ? 16'hFFFF : c; o_checksum_valid <= 1; next OUT. o_ready=0.
- OUT: o_ready=0; o_checksum and o_checksum_valid stable. On checksum transfer: o_checksum_valid <= 0, sum <= 0, next IDLE. o_checksum retains its value; o_word_count retains last packet count until the next packet's first word.
- i_valid without o_ready: the word is not consumed; upstream holds it.
- Reset (any state, any time): state IDLE, sum 0, o_checksum 16'h0000, o_checksum_valid 0, o_word_count 0; o_ready=1 once reset deasserts. A packet in progress is discarded; no partial checksum is emitted.

## Timing
- o_ready is combinational from state only (1 in IDLE/ACCUM), never from i_valid.
- One word per cycle sustained throughput within a packet.
- Last word accepted at edge k: FOLD1 at k+1, FOLD2 at k+2. o_checksum_valid=1 after edge k+2. Earliest new word accept is the cycle after the checksum transfer edge.
- Checksum accepted at edge m: o_checksum_valid=0 and o_ready=1 after edge m; minimum per-packet overhead 3 cycles plus the handshake cycle.
- i_checksum_ready high while valid is low has no effect.
- Single-word packet (i_last on the first word) is legal and follows the same latency.

## Test plan
- RFC 1071 vector: 0x0001, 0xF203, 0xF4F5, 0xF6F7 (last), i_checksum_ready=1 -> o_checksum=16'h220D, valid 2 cycles after the last-word edge, o_word_count=4.
- Double fold: 0xFFFF, 0xFFFF, 0x0001 (last) -> raw 0x1FFFF, FOLD1 0x10000, f=0x0001, o_checksum=16'hFFFE.
- Zero mapping: single word 0xFFFF (last), INIT_SUM=0 -> c=0x0000, o_checksum=16'hFFFF. Repeat with INIT_SUM=16'h1234 and words 0x0000, 0xEDCB (last) -> o_checksum=16'hFFFF.
- Odd length: 0x1234, 0x56AB with i_last=1, i_odd=1 -> sum 0x6834, o_checksum=16'h97CB.
- Back-pressure: hold i_checksum_ready=0 for 5 cycles after valid, with i_valid=1 -> o_checksum and o_checksum_valid remain stable, o_ready=0, no word consumed. Release -> IDLE next cycle, next packet's first word is accepted and its checksum is unaffected by the previous packet.
- Reset mid-packet: assert i_rst asynchronously after 2 of 4 words -> all outputs 0 immediately. Resend full RFC 1071 packet -> 16'h220D.
